// File: rtl/gol_sequencer_if.sv
// -----------------------------------------------------------------------------
// gol_sequencer_if
// Board-load handshake between a board source and the Game of Life sequencer.
//   i_load_valid  source -> sequencer  load request, held until o_load_ready
//   i_load_data   source -> sequencer  64-bit board, cell(r,c) = bit r*8+c
//   o_load_ready  sequencer -> source  sequencer is idle and will take a load
// -----------------------------------------------------------------------------
interface gol_sequencer_if;
    logic        i_load_valid;
    logic [63:0] i_load_data;
    logic        o_load_ready;

    modport master (
        output i_load_valid,
        output i_load_data,
        input  o_load_ready
    );

    modport slave (
        input  i_load_valid,
        input  i_load_data,
        output o_load_ready
    );
endinterface

// File: rtl/gol_sequencer.sv
// -----------------------------------------------------------------------------
// gol_sequencer
// Generation sequencer for an 8x8 Game of Life board (B3/S23). Holds the
// current board, computes the next generation one row per clock into a
// separate next board, and commits it in a single cycle so that o_frame only
// ever shows complete generations. Generations are paced by a tick counter
// (i_run) or by single-step requests (i_step).
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-low reset
//   load_if        board load handshake (slave side)
//   i_run          level, enables periodic generations
//   i_step         single-generation request, honoured only in IDLE
//   o_frame        committed board for the LED matrix driver
//   o_frame_valid  one-cycle pulse whenever o_frame is written
//   o_busy         high while computing or committing
//   o_generation   generations since the last load (wraps)
//   o_extinct      committed board is all zero
//   o_overrun      sticky: a tick arrived while not idle; cleared by load
// -----------------------------------------------------------------------------
module gol_sequencer #(
    parameter int unsigned TICKS_PER_GEN = 32'd8000000,
    parameter bit          WRAP          = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    gol_sequencer_if.slave        load_if,
    input  logic                  i_run,
    input  logic                  i_step,
    output logic [63:0]           o_frame,
    output logic                  o_frame_valid,
    output logic                  o_busy,
    output logic [15:0]           o_generation,
    output logic                  o_extinct,
    output logic                  o_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    localparam logic [31:0] TICK_LAST = 32'(TICKS_PER_GEN - 32'd1);

    state_t      state_r;
    state_t      state_nx_s;
    logic [2:0]  row_r;
    logic [63:0] cur_r;
    logic [63:0] next_r;
    logic [63:0] frame_r;
    logic [31:0] tick_cnt_r;
    logic        tick_s;
    logic        load_take_s;
    logic [7:0]  row_next_s;
    logic        frame_valid_r;
    logic        busy_r;
    logic        ready_r;
    logic [15:0] gen_r;
    logic        extinct_r;
    logic        overrun_r;

    // Next state of row r of the board under B3/S23. Row/column neighbours use
    // 3-bit arithmetic, which wraps mod 8 for free; without WRAP the
    // out-of-board neighbours are masked to dead instead.
    function automatic logic [7:0] next_row(input logic [63:0] board,
                                            input logic [2:0]  r);
        logic [2:0] ru;
        logic [2:0] rd;
        logic [7:0] up;
        logic [7:0] mid;
        logic [7:0] dn;
        logic [2:0] col;
        logic [2:0] cl;
        logic [2:0] cr;
        logic       l_ok;
        logic       r_ok;
        logic [3:0] cnt;
        logic [7:0] res;
        ru  = r - 3'd1;
        rd  = r + 3'd1;
        mid = board[{r, 3'b000} +: 8];
        up  = (WRAP || (r != 3'd0)) ? board[{ru, 3'b000} +: 8] : 8'd0;
        dn  = (WRAP || (r != 3'd7)) ? board[{rd, 3'b000} +: 8] : 8'd0;
        res = 8'd0;
        for (int c = 32'sd0; c < 32'sd8; c++) begin
            col  = 3'(c);
            cl   = col - 3'd1;
            cr   = col + 3'd1;
            l_ok = WRAP || (col != 3'd0);
            r_ok = WRAP || (col != 3'd7);
            cnt  = {3'b000, up[cl] & l_ok}  + {3'b000, up[col]} + {3'b000, up[cr] & r_ok}
                 + {3'b000, mid[cl] & l_ok}                     + {3'b000, mid[cr] & r_ok}
                 + {3'b000, dn[cl] & l_ok}  + {3'b000, dn[col]} + {3'b000, dn[cr] & r_ok};
            res[col] = (cnt == 4'd3) || (mid[col] && (cnt == 4'd2));
        end
        return res;
    endfunction

    // Tick decode, load acceptance and the row currently being evaluated.
    always_comb begin
        tick_s      = 1'b0;
        load_take_s = 1'b0;
        if (i_run && (tick_cnt_r == TICK_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        if ((state_r == ST_IDLE) && load_if.i_load_valid) begin
            load_take_s = 1'b1;
        end else begin
            load_take_s = 1'b0;
        end
        row_next_s = next_row(cur_r, row_r);
    end

    // Generation period counter; a load restarts the period.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tick_cnt_r <= 32'd0;
        end else if (!i_run || load_take_s || tick_s) begin
            tick_cnt_r <= 32'd0;
        end else begin
            tick_cnt_r <= tick_cnt_r + 32'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state; a load in IDLE takes priority over tick and step.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_take_s) begin
                    state_nx_s = ST_IDLE;
                end else if (tick_s || i_step) begin
                    state_nx_s = ST_COMPUTE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (row_r == 3'd7) begin
                    state_nx_s = ST_COMMIT;
                end else begin
                    state_nx_s = ST_COMPUTE;
                end
            end
            ST_COMMIT: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // Board datapath and registered status outputs. Rows only ever land in
    // next_r, so an interrupted generation never reaches cur_r or the frame.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            row_r         <= 3'd0;
            cur_r         <= 64'd0;
            next_r        <= 64'd0;
            frame_r       <= 64'd0;
            gen_r         <= 16'd0;
            frame_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            ready_r       <= 1'b1;
            extinct_r     <= 1'b1;
            overrun_r     <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            ready_r       <= (state_nx_s == ST_IDLE);
            busy_r        <= (state_nx_s != ST_IDLE);
            if (tick_s && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
            case (state_r)
                ST_IDLE: begin
                    row_r <= 3'd0;
                    if (load_take_s) begin
                        cur_r         <= load_if.i_load_data;
                        frame_r       <= load_if.i_load_data;
                        gen_r         <= 16'd0;
                        overrun_r     <= 1'b0;
                        frame_valid_r <= 1'b1;
                        extinct_r     <= (load_if.i_load_data == 64'd0);
                    end else begin
                        cur_r <= cur_r;
                    end
                end
                ST_COMPUTE: begin
                    next_r[{row_r, 3'b000} +: 8] <= row_next_s;
                    row_r                        <= row_r + 3'd1;
                end
                ST_COMMIT: begin
                    cur_r         <= next_r;
                    frame_r       <= next_r;
                    gen_r         <= gen_r + 16'd1;
                    frame_valid_r <= 1'b1;
                    extinct_r     <= (next_r == 64'd0);
                end
                default: begin
                    row_r <= 3'd0;
                end
            endcase
        end
    end

    assign load_if.o_load_ready = ready_r;
    assign o_frame              = frame_r;
    assign o_frame_valid        = frame_valid_r;
    assign o_busy               = busy_r;
    assign o_generation         = gen_r;
    assign o_extinct            = extinct_r;
    assign o_overrun            = overrun_r;

endmodule

// File: doc/gol_sequencer.md
# gol_sequencer

Generation sequencer for the 8x8 Game of Life board. Holds the current 64-bit board and computes the next generation one row per clock (B3/S23 rules). It paces generations from a tick counter or single-step requests. It presents the committed board as a stable 64-bit frame to the LED matrix driver's `i_data` input. Board loads use a valid/ready handshake.

## Interface
- `TICKS_PER_GEN`, default 8000000: generation period in clocks while running; legal range ≥ 10.
- `WRAP`, default 1: 1 = toroidal edges; 0 = out-of-board neighbours are dead.

- `i_clk`  in  1  system clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_load_valid`  in  1  load request.
- `i_load_data`  in  64  board to load; cell(r,c) = bit r*8+c.
- `o_load_ready`  out  1  high exactly when state = IDLE.
- `i_run`  in  1  level; enables periodic generations.
- `i_step`  in  1  single-generation request, sampled in IDLE.
- `o_frame`  out  64  committed board; feeds the LED driver `i_data`.
- `o_frame_valid`  out  1  one-cycle pulse when `o_frame` changes.
- `o_busy`  out  1  high in COMPUTE and COMMIT.
- `o_generation`  out  16  generation count since last load; wraps 0xFFFF→0.
- `o_extinct`  out  1  high while the committed board is all zero.
- `o_overrun`  out  1  sticky; a tick arrived while not IDLE. Cleared by load or reset.

## Operation
- States: IDLE, COMPUTE, COMMIT.
- Reset (async, `i_reset` = 0) sets:
  - state IDLE and row index 0;
  - current board, next board, `o_frame`, `o_generation` and tick counter to 0;
  - `o_frame_valid`, `o_busy` and `o_overrun` to 0;
  - `o_extinct` to 1 and `o_load_ready` to 1.
- Tick counter, while `i_run` = 1:
  - increments every cycle in any state;
  - at TICKS_PER_GEN-1 it raises an internal tick for that cycle and wraps to 0.
- `i_run` = 0 clears the tick counter to 0.
- IDLE, priority order:
  - (1) `i_load_valid`: current ← `i_load_data`, `o_frame` ← `i_load_data`, `o_generation` ← 0, tick counter ← 0, `o_overrun` ← 0, `o_frame_valid` pulses; stay in IDLE.
  - (2) Else a tick, or `i_step` = 1: go to COMPUTE with row index 0.
  - (3) Else hold.
- COMPUTE (row index r = 0..7, one row per cycle):
  - For each column c, count the 8 neighbours of cell(r,c) in the current board. The count is 4 bits, 0..8.
  - Neighbour rows are r±1 and columns c±1, taken mod 8 when WRAP = 1; dropped when WRAP = 0.
  - next(r,c) = 1 if count = 3, or if cell is alive and count = 2; else 0.
  - At r = 7, go to COMMIT.
- COMMIT (one cycle):
  - current ← next, `o_frame` ← next, `o_generation` ← `o_generation` + 1;
  - `o_frame_valid` pulses; return to IDLE.
- `o_extinct` = (`o_frame` == 0), updated whenever `o_frame` is.
- A tick while in COMPUTE or COMMIT is dropped and sets `o_overrun`.
- `i_step` and `i_load_valid` are ignored outside IDLE; the requester holds `i_load_valid` until it sees `o_load_ready`.
- `i_run` falling mid-generation does not abort it; the generation completes.
- The current board is not modified during COMPUTE. Row updates write only to the next board.

## Timing
- Trigger sampled at edge E0 → COMPUTE during E1..E8 (row r processed at edge E(r+1)) → COMMIT at E9.
- `o_frame` is updated and `o_frame_valid` is high for the cycle following E9.
- `o_busy` is high in the cycles following E0..E8. Latency from trigger to frame is 9 edges; minimum generation spacing is 10 cycles.
- Load: accepted at the sampling edge; `o_frame` is visible and `o_frame_valid` is high in the next cycle; no busy period.
- With `i_run` held high, ticks are exactly TICKS_PER_GEN cycles apart, so frames are TICKS_PER_GEN cycles apart.
- `o_frame` is a register and stable between commits; the LED driver may sample it asynchronously to its row scan.
- Reset asserted mid-COMPUTE: all outputs take reset values immediately. No partial next board is ever committed.

## Test plan
- Blinker, WRAP = 1: load 0x000000001C000000 then step → `o_frame` 0x0000000808080000 after 9 edges, `o_generation` 1. Step again → 0x000000001C000000, `o_generation` 2.
- Wrap edges: load 0x83 and step. WRAP = 1 → 0x0100000000000101. WRAP = 0 → 0x0 with `o_extinct` 1.
- Still life and extinction: block 0x303 stays 0x303 over 3 steps. Single cell 0x1 → 0x0 and `o_extinct` 1.
- Run pacing, TICKS_PER_GEN = 16: `i_run` high → `o_frame_valid` pulses exactly 16 cycles apart and `o_overrun` stays 0. With TICKS_PER_GEN = 8 → `o_overrun` sets on the first tick that lands while busy.
- Load priority: `i_load_valid`, `i_step` and a tick in the same IDLE cycle → load wins, no COMPUTE, `o_generation` 0. Load during COMPUTE → `o_load_ready` 0, load accepted on the first IDLE cycle.
- Reset mid-COMPUTE at row 4 → `o_frame` 0, `o_busy` 0, `o_extinct` 1, state IDLE. A subsequent step on the empty board yields 0x0.
